smc_apb_regif_lite: RTL and testbench



---
 rtl/smc_lite_pkg.sv | 52 +++++
 rtl/smc_apb_decode_lite.sv | 36 +++
 rtl/smc_apb_regif_lite_chk.sv | 19 +
 rtl/smc_apb_regif_lite.sv | 175 +++++++++++++++++
 tb/tb_smc_apb_regif_lite.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/smc_lite_pkg.sv
// Shared types and constants for the lite static memory controller register front-end.
package smc_lite_pkg;

  // APB slave sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } smc_state_e;

  // Kind of transfer captured at the SETUP->ACCESS edge.
  typedef enum logic [1:0] {
    ACC_CFG      = 2'd0,
    ACC_ID       = 2'd1,
    ACC_UNMAPPED = 2'd2,
    ACC_WRITE    = 2'd3
  } smc_acc_kind_e;

  // Register map (byte offsets, word aligned).
  localparam logic [11:0] SMC_CFG_OFFSET = 12'h000;
  localparam logic [11:0] SMC_ID_OFFSET  = 12'h004;

  // Constant returned by the peripheral ID register.
  localparam logic [31:0] SMC_PERIPH_ID  = 32'h0001_5C01;

  // Response codes carried on pslverr.
  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  // Classify a transfer from direction and decode result. Writes are always
  // rejected because every register in this space is read-only.
  function automatic smc_acc_kind_e classify(input logic is_write,
                                             input logic hit_cfg,
                                             input logic hit_id,
                                             input logic unmapped);
    smc_acc_kind_e kind;
    if (is_write) begin
      kind = ACC_WRITE;
    end else if (unmapped) begin
      kind = ACC_UNMAPPED;
    end else if (hit_cfg) begin
      kind = ACC_CFG;
    end else if (hit_id) begin
      kind = ACC_ID;
    end else begin
      kind = ACC_UNMAPPED;
    end
    return kind;
  endfunction

endpackage

// File: rtl/smc_apb_decode_lite.sv
// Combinational word-aligned offset decode for the register front-end.
module smc_apb_decode_lite
  import smc_lite_pkg::*;
#(
  parameter int unsigned         ADDR_W     = 12,
  parameter logic [ADDR_W-1:0]   CFG_OFFSET = ADDR_W'(SMC_CFG_OFFSET),
  parameter logic [ADDR_W-1:0]   ID_OFFSET  = ADDR_W'(SMC_ID_OFFSET)
) (
  input  logic [ADDR_W-1:0] paddr,
  output logic              hit_cfg,
  output logic              hit_id,
  output logic              unmapped
);

  // Byte-lane bits [1:0] are masked off so any byte address inside a word hits.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(2'b11));

  // Compare the word part of the address against each register offset.
  always_comb begin
    hit_cfg  = 1'b0;
    hit_id   = 1'b0;
    unmapped = 1'b1;
    if (((paddr ^ CFG_OFFSET) & WORD_MASK) == '0) begin
      hit_cfg = 1'b1;
    end else begin
      hit_cfg = 1'b0;
    end
    if (((paddr ^ ID_OFFSET) & WORD_MASK) == '0) begin
      hit_id = 1'b1;
    end else begin
      hit_id = 1'b0;
    end
    unmapped = !(hit_cfg || hit_id);
  end

endmodule

// File: rtl/smc_apb_regif_lite_chk.sv
// Simulation-only sanity checks for the register front-end.
module smc_apb_regif_lite_chk #(
  parameter int unsigned WAIT_STATES = 1
) (
  input logic pclk,
  input logic n_preset,
  input logic pready,
  input logic pslverr
);

  // Wait count must fit the 3-bit counter; an error is only legal with pready.
  always @(posedge pclk) begin
    if (n_preset) begin
      assert (WAIT_STATES <= 32'd7);
      assert (!pslverr || pready);
    end
  end

endmodule

// File: rtl/smc_apb_regif_lite.sv
// APB3 read-only register front-end for the lite SMC: decode, wait states,
// registered read data and error response.
module smc_apb_regif_lite
  import smc_lite_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] CFG_OFFSET  = ADDR_W'(SMC_CFG_OFFSET),
  parameter logic [ADDR_W-1:0] ID_OFFSET   = ADDR_W'(SMC_ID_OFFSET),
  parameter logic [31:0]       PERIPH_ID   = SMC_PERIPH_ID
) (
  input  logic              pclk,
  input  logic              n_preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              selreg,
  input  logic [31:0]       cfg_rdata
);

  // Counter value at which the final ACCESS cycle is reached.
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

  smc_state_e    state_q, state_d;
  smc_acc_kind_e kind_q, kind_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   prdata_q, prdata_d;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;
  logic          selreg_q, selreg_d;

  logic          hit_cfg_s, hit_id_s, unmapped_s;
  logic          unused_pwdata_s;

  // Write data is never stored: all registers are read-only.
  assign unused_pwdata_s = ^pwdata;

  smc_apb_decode_lite #(
    .ADDR_W     (ADDR_W),
    .CFG_OFFSET (CFG_OFFSET),
    .ID_OFFSET  (ID_OFFSET)
  ) u_decode (
    .paddr    (paddr),
    .hit_cfg  (hit_cfg_s),
    .hit_id   (hit_id_s),
    .unmapped (unmapped_s)
  );

  smc_apb_regif_lite_chk #(
    .WAIT_STATES (WAIT_STATES)
  ) u_chk (
    .pclk     (pclk),
    .n_preset (n_preset),
    .pready   (pready_q),
    .pslverr  (pslverr_q)
  );

  // Next-state logic: transfer sequencing, wait counting and transfer capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    case (state_q)
      ST_IDLE: begin
        // penable without a preceding setup phase never starts a transfer.
        if (psel && !penable) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
          cnt_d   = 3'd0;
          kind_d  = classify(pwrite, hit_cfg_s, hit_id_s, unmapped_s);
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        // A setup phase already on the bus is accepted without an idle cycle.
        if (psel && !penable) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Output next-values: response is loaded on the ACCESS->DONE edge only.
  always_comb begin
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = RESP_OKAY;
    if ((state_q == ST_ACCESS) && (state_d == ST_DONE)) begin
      pready_d = 1'b1;
      case (kind_q)
        ACC_CFG: begin
          prdata_d  = cfg_rdata;
          pslverr_d = RESP_OKAY;
        end
        ACC_ID: begin
          prdata_d  = PERIPH_ID;
          pslverr_d = RESP_OKAY;
        end
        ACC_UNMAPPED: begin
          prdata_d  = 32'h0000_0000;
          pslverr_d = RESP_SLVERR;
        end
        ACC_WRITE: begin
          prdata_d  = prdata_q;
          pslverr_d = RESP_SLVERR;
        end
        default: begin
          prdata_d  = prdata_q;
          pslverr_d = RESP_SLVERR;
        end
      endcase
    end else begin
      pready_d  = 1'b0;
      pslverr_d = RESP_OKAY;
    end
    // selreg spans ACCESS and DONE of a config read.
    selreg_d = ((state_d == ST_ACCESS) || (state_d == ST_DONE)) && (kind_d == ACC_CFG);
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge pclk or negedge n_preset) begin
    if (!n_preset) begin
      state_q   <= ST_IDLE;
      kind_q    <= ACC_UNMAPPED;
      cnt_q     <= 3'd0;
      prdata_q  <= 32'h0000_0000;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      selreg_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      selreg_q  <= selreg_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign selreg  = selreg_q;

endmodule

// File: tb/tb_smc_apb_regif_lite.sv
// Self-checking bench for smc_apb_regif_lite: directed and random APB reads and
// writes compared against a transaction-level reference model.
module tb_smc_apb_regif_lite;

  localparam int unsigned WS    = 1;
  localparam int unsigned BOUND = 20;

  logic        pclk = 1'b0;
  logic        n_preset;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata, cfg_rdata;
  logic        pready, pslverr, selreg;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_prdata;

  always #5 pclk = ~pclk;

  smc_apb_regif_lite #(
    .ADDR_W      (12),
    .WAIT_STATES (WS)
  ) dut (
    .pclk      (pclk),
    .n_preset  (n_preset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .selreg    (selreg),
    .cfg_rdata (cfg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what a completed transfer must return, from the register map.
  function automatic void model(input logic [11:0] addr, input logic wr,
                                input logic [31:0] cfg, output logic [31:0] rd,
                                output logic err, output int sel_cycles);
    int word;
    word = int'(addr) / 4;
    if (wr) begin
      rd = exp_prdata; err = 1'b1; sel_cycles = 0;
    end else if (word == 0) begin
      rd = cfg; err = 1'b0; sel_cycles = 2 + int'(WS);
    end else if (word == 1) begin
      rd = 32'h0001_5C01; err = 1'b0; sel_cycles = 0;
    end else begin
      rd = 32'h0000_0000; err = 1'b1; sel_cycles = 0;
    end
  endfunction

  task automatic idle(input int n);
    psel = 1'b0;
    penable = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge pclk); #1;
      chk("idle_pready", {31'd0, pready}, 32'd0);
      chk("idle_selreg", {31'd0, selreg}, 32'd0);
    end
  endtask

  // One APB transfer. b2b=1 means the setup phase is driven in the DONE cycle
  // of the previous transfer (caller is at that DONE cycle's falling edge).
  task automatic xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [31:0] cfg, input bit b2b);
    logic [31:0] e_rd;
    logic        e_err;
    int          e_sel, cyc, sel_cnt;
    bit          seen;
    model(addr, wr, cfg, e_rd, e_err, e_sel);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; cfg_rdata = cfg;
    cyc = 0; sel_cnt = 0; seen = 1'b0;
    if (!b2b) begin
      @(negedge pclk);
      if (selreg) sel_cnt++;
      chk("setup_pready", {31'd0, pready}, 32'd0);
    end
    while (!seen && cyc < int'(BOUND)) begin
      @(posedge pclk); #1;
      cyc++;
      if (cyc == 1) penable = 1'b1;
      @(negedge pclk);
      if (selreg) sel_cnt++;
      if (pready) seen = 1'b1;
      else chk("pslverr_wo_pready", {31'd0, pslverr}, 32'd0);
    end
    chk("latency", cyc, 3 + WS);
    chk("prdata", prdata, e_rd);
    chk("pslverr", {31'd0, pslverr}, {31'd0, e_err});
    chk("selreg_cycles", sel_cnt, e_sel);
    exp_prdata = e_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [11:0] a;
    logic        w;
    bit          b2b;
    n_preset = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h000; pwdata = 32'h0; cfg_rdata = 32'h0; exp_prdata = 32'h0;

    // Reset held with psel asserted: all outputs stay at reset values.
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_pready", {31'd0, pready}, 32'd0);
      chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
      chk("rst_selreg", {31'd0, selreg}, 32'd0);
    end
    psel = 1'b0;
    n_preset = 1'b1;
    idle(2);

    // Directed: config read, ID read, write, unmapped read + back-to-back config read.
    xfer(12'h000, 1'b0, 32'h0, 32'hC000_0001, 1'b0);
    idle(1);
    xfer(12'h004, 1'b0, 32'h0, 32'h0BAD_0BAD, 1'b0);
    idle(1);
    xfer(12'h000, 1'b1, 32'hFFFF_FFFF, 32'h1111_2222, 1'b0);
    idle(1);
    xfer(12'h0F0, 1'b0, 32'h0, 32'h3333_4444, 1'b0);
    xfer(12'h000, 1'b0, 32'h0, 32'h1234_5678, 1'b1);
    idle(1);

    // Random traffic, mixing idle gaps and back-to-back transfers.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 12'h000;
        1: a = 12'h004;
        2: a = 12'h0F0;
        default: a = 12'($urandom);
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 3) == 0);
      b2b = (i != 0) && ($urandom_range(0, 2) != 0);
      if (!b2b) idle(1 + int'($urandom_range(0, 2)));
      xfer(a, w, $urandom, $urandom, b2b);
    end
    idle(2);

    // Reset asserted during ACCESS of a config read.
    psel = 1'b1; penable = 1'b0; paddr = 12'h000; pwrite = 1'b0; cfg_rdata = 32'hA5A5_0F0F;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1;
    chk("abort_sel_before", {31'd0, selreg}, 32'd1);
    #2 n_preset = 1'b0;
    #1;
    chk("abort_selreg", {31'd0, selreg}, 32'd0);
    chk("abort_pready", {31'd0, pready}, 32'd0);
    chk("abort_prdata", prdata, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge pclk); #1;
      chk("abort_hold_pready", {31'd0, pready}, 32'd0);
    end
    psel = 1'b0; penable = 1'b0;
    n_preset = 1'b1;
    exp_prdata = 32'h0;
    idle(1);
    xfer(12'h000, 1'b0, 32'h0, 32'h600D_F00D, 1'b0);
    idle(1);

    // psel dropped during ACCESS: no completion, selreg falls, prdata kept.
    psel = 1'b1; penable = 1'b0; paddr = 12'h000; pwrite = 1'b0; cfg_rdata = 32'hDEAD_BEEF;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge pclk); #1;
      chk("drop_pready", {31'd0, pready}, 32'd0);
      chk("drop_selreg", {31'd0, selreg}, 32'd0);
    end
    chk("drop_prdata", prdata, exp_prdata);

    // penable seen in IDLE never starts a transfer.
    psel = 1'b1; penable = 1'b1; paddr = 12'h000; pwrite = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge pclk); #1;
      chk("penable_idle_pready", {31'd0, pready}, 32'd0);
      chk("penable_idle_selreg", {31'd0, selreg}, 32'd0);
    end
    idle(1);
    xfer(12'h004, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
